// File: rtl/alu_exec_wb_if.sv
// Issue, flush and common-data-broadcast signals shared by the ALU RS,
// the execute/writeback stage and the CDB arbiter.
interface alu_exec_wb_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int NAME_W = 5,
  parameter int OP_W   = 5
);
  logic              workEn;
  logic [DATA_W-1:0] operandO;
  logic [DATA_W-1:0] operandT;
  logic [OP_W-1:0]   opCode;
  logic [TAG_W-1:0]  wrtTag;
  logic [NAME_W-1:0] wrtName;
  logic [DATA_W-1:0] instAddr;
  logic              flush;
  logic              cdbGrant;
  logic              aluBusy;
  logic              cdbReq;
  logic              enALUwrt;
  logic [TAG_W-1:0]  ALUtag;
  logic [DATA_W-1:0] ALUdata;
  logic [NAME_W-1:0] ALUname;
  logic              overflow;

  modport master (
    output workEn, operandO, operandT, opCode, wrtTag, wrtName, instAddr, flush, cdbGrant,
    input  aluBusy, cdbReq, enALUwrt, ALUtag, ALUdata, ALUname, overflow
  );

  modport slave (
    input  workEn, operandO, operandT, opCode, wrtTag, wrtName, instAddr, flush, cdbGrant,
    output aluBusy, cdbReq, enALUwrt, ALUtag, ALUdata, ALUname, overflow
  );
endinterface

// File: rtl/alu_exec_wb.sv
// ALU execute/writeback stage: single-cycle ALU feeding an in-order result
// FIFO whose head drives the common data broadcast when the arbiter grants it.
module alu_exec_wb #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int NAME_W = 5,
  parameter int OP_W   = 5,
  parameter int DEPTH  = 2
) (
  input logic          clk,
  input logic          rst,
  alu_exec_wb_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [TAG_W-1:0] TAG_FREE = '1;

  localparam logic [OP_W-1:0] OP_NOP   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(9);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(10);
  localparam logic [OP_W-1:0] OP_LUI   = OP_W'(11);
  localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(12);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(13);
  localparam logic [OP_W-1:0] OP_JALR  = OP_W'(14);

  logic [TAG_W-1:0]  r_tag  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [NAME_W-1:0] r_name [DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;

  logic [DATA_W-1:0] w_result;
  logic [4:0]        w_shamt;
  logic              w_issue;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_cdbReq;

  assign w_shamt = bus.operandT[4:0];

  always_comb begin
    w_result = '0;
    case (bus.opCode)
      OP_ADD:          w_result = bus.operandO + bus.operandT;
      OP_SUB:          w_result = bus.operandO - bus.operandT;
      OP_SLL:          w_result = bus.operandO << w_shamt;
      OP_SRL:          w_result = bus.operandO >> w_shamt;
      OP_SRA:          w_result = $unsigned($signed(bus.operandO) >>> w_shamt);
      OP_SLT:          w_result = DATA_W'($signed(bus.operandO) < $signed(bus.operandT));
      OP_SLTU:         w_result = DATA_W'(bus.operandO < bus.operandT);
      OP_XOR:          w_result = bus.operandO ^ bus.operandT;
      OP_OR:           w_result = bus.operandO | bus.operandT;
      OP_AND:          w_result = bus.operandO & bus.operandT;
      OP_LUI:          w_result = bus.operandT;
      OP_AUIPC:        w_result = bus.instAddr + bus.operandT;
      OP_JAL, OP_JALR: w_result = bus.instAddr + DATA_W'(4);
      default:         w_result = '0;
    endcase
  end

  // A full FIFO still accepts an issue when the head leaves in the same cycle.
  assign w_cdbReq = (r_count != '0);
  assign w_full   = (r_count >= CNT_W'(DEPTH));
  assign w_pop    = w_cdbReq & bus.cdbGrant;
  assign w_issue  = bus.workEn & (bus.opCode != OP_NOP) & (bus.wrtTag != TAG_FREE);
  assign w_push   = w_issue & (~w_full | w_pop) & ~bus.flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (bus.flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_issue && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  // Entry storage needs no reset: r_count alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag[r_wrPtr]  <= bus.wrtTag;
      r_data[r_wrPtr] <= w_result;
      r_name[r_wrPtr] <= bus.wrtName;
    end
  end

  assign bus.cdbReq   = w_cdbReq;
  assign bus.enALUwrt = w_pop;
  assign bus.ALUtag   = w_cdbReq ? r_tag[r_rdPtr]  : TAG_FREE;
  assign bus.ALUdata  = w_cdbReq ? r_data[r_rdPtr] : '0;
  assign bus.ALUname  = w_cdbReq ? r_name[r_rdPtr] : '0;
  assign bus.aluBusy  = (r_count >= CNT_W'(DEPTH - 1));
  assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_alu_exec_wb.sv
// Bench for alu_exec_wb: directed scenarios plus random traffic checked
// against a queue-based reference of the result FIFO.
module tb_alu_exec_wb;
  localparam int DEPTH = 2;

  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_SLL   = 5'd3;
  localparam logic [4:0] OP_SRL   = 5'd4;
  localparam logic [4:0] OP_SRA   = 5'd5;
  localparam logic [4:0] OP_SLT   = 5'd6;
  localparam logic [4:0] OP_SLTU  = 5'd7;
  localparam logic [4:0] OP_XOR   = 5'd8;
  localparam logic [4:0] OP_OR    = 5'd9;
  localparam logic [4:0] OP_AND   = 5'd10;
  localparam logic [4:0] OP_LUI   = 5'd11;
  localparam logic [4:0] OP_AUIPC = 5'd12;
  localparam logic [4:0] OP_JAL   = 5'd13;
  localparam logic [4:0] OP_JALR  = 5'd14;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] data;
    logic [4:0]  name;
  } entry_t;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] exp;
  } opv_t;

  logic clk;
  logic rst;
  int   nVec;
  int   nErr;

  entry_t q[$];
  bit     mOvf;
  opv_t   tv[6];

  alu_exec_wb_if bus ();

  alu_exec_wb #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Result of an op computed from its arithmetic definition.
  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] pc);
    logic [31:0] p2;
    p2 = 32'd1 << b[4:0];
    case (op)
      OP_ADD:          return a + b;
      OP_SUB:          return a - b;
      OP_SLL:          return a * p2;
      OP_SRL:          return a / p2;
      OP_SRA:          return (a / p2) | (a[31] ? ~(32'hFFFF_FFFF / p2) : 32'd0);
      OP_SLT:          return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU:         return (a < b) ? 32'd1 : 32'd0;
      OP_XOR:          return a ^ b;
      OP_OR:           return a | b;
      OP_AND:          return a & b;
      OP_LUI:          return b;
      OP_AUIPC:        return pc + b;
      OP_JAL, OP_JALR: return pc + 32'd4;
      default:         return 32'd0;
    endcase
  endfunction

  function automatic logic [44:0] snap();
    return {bus.cdbReq, bus.enALUwrt, bus.aluBusy, bus.overflow,
            bus.ALUtag, bus.ALUname, bus.ALUdata};
  endfunction

  function automatic logic [44:0] mk(input bit req, input bit en, input bit busy, input bit ovf,
                                     input logic [3:0] tag, input logic [4:0] name,
                                     input logic [31:0] data);
    return {req, en, busy, ovf, tag, name, data};
  endfunction

  function automatic logic [44:0] modelOut();
    bit req;
    req = (q.size() != 0);
    if (!req) return mk(1'b0, 1'b0, q.size() >= DEPTH - 1, mOvf, 4'hF, 5'd0, 32'd0);
    return mk(1'b1, bus.cdbGrant, q.size() >= DEPTH - 1, mOvf, q[0].tag, q[0].name, q[0].data);
  endfunction

  task automatic setIssue(input bit en, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] tag, input logic [4:0] name,
                          input logic [31:0] pc);
    bus.workEn   = en;
    bus.opCode   = op;
    bus.operandO = a;
    bus.operandT = b;
    bus.wrtTag   = tag;
    bus.wrtName  = name;
    bus.instAddr = pc;
  endtask

  task automatic idle();
    setIssue(1'b0, OP_NOP, 32'd0, 32'd0, 4'hF, 5'd0, 32'd0);
    bus.flush = 1'b0;
  endtask

  // Advance the reference across one clock edge, then let the DUT take it.
  task automatic tick();
    bit issue;
    bit full;
    bit pop;
    entry_t e;
    issue = bus.workEn && (bus.opCode != OP_NOP) && (bus.wrtTag != 4'hF);
    full  = (q.size() >= DEPTH);
    pop   = (q.size() != 0) && bus.cdbGrant;
    if (bus.flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (issue && (!full || pop)) begin
        e.tag  = bus.wrtTag;
        e.name = bus.wrtName;
        e.data = ref_alu(bus.opCode, bus.operandO, bus.operandT, bus.instAddr);
        q.push_back(e);
      end else if (issue) begin
        mOvf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [44:0] got;
    rst = 1'b0;
    idle();
    bus.cdbGrant = 1'b0;
    #12;
    got = snap();
    nVec++;
    if (got !== mk(0, 0, 0, 0, 4'hF, 5'd0, 32'd0)) begin
      nErr++;
      $display("[TB] FAIL reset_outputs got %h exp %h", got, mk(0, 0, 0, 0, 4'hF, 5'd0, 32'd0));
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    logic [44:0] got;
    bus.cdbGrant = 1'b1;
    setIssue(1'b1, OP_ADD, 32'd5, 32'd7, 4'd3, 5'd10, 32'd0);
    #1;
    got = snap();
    nVec++;
    if (got !== mk(0, 0, 0, 0, 4'hF, 5'd0, 32'd0)) begin
      nErr++;
      $display("[TB] FAIL add_no_comb_path got %h exp %h", got, mk(0, 0, 0, 0, 4'hF, 5'd0, 32'd0));
    end
    tick();
    idle();
    #1;
    got = snap();
    nVec++;
    if (got !== mk(1, 1, 1, 0, 4'd3, 5'd10, 32'd12)) begin
      nErr++;
      $display("[TB] FAIL add_broadcast got %h exp %h", got, mk(1, 1, 1, 0, 4'd3, 5'd10, 32'd12));
    end
    tick();
    got = snap();
    nVec++;
    if (got !== mk(0, 0, 0, 0, 4'hF, 5'd0, 32'd0)) begin
      nErr++;
      $display("[TB] FAIL add_drained got %h exp %h", got, mk(0, 0, 0, 0, 4'hF, 5'd0, 32'd0));
    end
  endtask

  task automatic test_ops();
    tv[0] = '{OP_SUB,   32'd0,          32'd1,          32'd0,      32'hFFFF_FFFF};
    tv[1] = '{OP_SRA,   32'h8000_0000,  32'd4,          32'd0,      32'hF800_0000};
    tv[2] = '{OP_SLTU,  32'd1,          32'hFFFF_FFFF,  32'd0,      32'd1};
    tv[3] = '{OP_SLT,   32'h8000_0005,  32'h8000_0005,  32'd0,      32'd0};
    tv[4] = '{OP_JAL,   32'd9,          32'd9,          32'h100,    32'h104};
    tv[5] = '{OP_AUIPC, 32'd0,          32'h200,        32'h1000,   32'h1200};
    bus.cdbGrant = 1'b1;
    for (int i = 0; i < 6; i++) begin
      setIssue(1'b1, tv[i].op, tv[i].a, tv[i].b, 4'(i + 1), 5'(i + 20), tv[i].pc);
      tick();
      idle();
      #1;
      nVec++;
      if ({bus.enALUwrt, bus.ALUtag, bus.ALUdata} !== {1'b1, 4'(i + 1), tv[i].exp}) begin
        nErr++;
        $display("[TB] FAIL op_result[%0d] got en=%0b tag=%0d data=%h exp en=1 tag=%0d data=%h",
                 i, bus.enALUwrt, bus.ALUtag, bus.ALUdata, i + 1, tv[i].exp);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [44:0] got;
    logic [44:0] exp[4];
    bus.cdbGrant = 1'b0;
    setIssue(1'b1, OP_ADD, 32'd1, 32'd1, 4'd1, 5'd1, 32'd0);
    tick();
    setIssue(1'b1, OP_ADD, 32'd2, 32'd2, 4'd2, 5'd2, 32'd0);
    #1;
    got = snap();
    nVec++;
    if (got !== mk(1, 0, 1, 0, 4'd1, 5'd1, 32'd2)) begin
      nErr++;
      $display("[TB] FAIL order_busy_after_push got %h exp %h", got, mk(1, 0, 1, 0, 4'd1, 5'd1, 32'd2));
    end
    tick();
    idle();
    bus.cdbGrant = 1'b1;
    exp[0] = mk(1, 1, 1, 0, 4'd1, 5'd1, 32'd2);
    exp[1] = mk(1, 1, 1, 0, 4'd2, 5'd2, 32'd4);
    exp[2] = mk(0, 0, 0, 0, 4'hF, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      got = snap();
      nVec++;
      if (got !== exp[i]) begin
        nErr++;
        $display("[TB] FAIL order_step[%0d] got %h exp %h", i, got, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_full();
    logic [44:0] got;
    logic [44:0] exp;
    bus.cdbGrant = 1'b0;
    setIssue(1'b1, OP_ADD, 32'd10, 32'd1, 4'd1, 5'd1, 32'd0);
    tick();
    setIssue(1'b1, OP_ADD, 32'd20, 32'd2, 4'd2, 5'd2, 32'd0);
    tick();
    bus.cdbGrant = 1'b1;
    setIssue(1'b1, OP_ADD, 32'd30, 32'd3, 4'd3, 5'd3, 32'd0);
    #1;
    got = snap();
    exp = mk(1, 1, 1, 0, 4'd1, 5'd1, 32'd11);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("[TB] FAIL full_push_pop_head got %h exp %h", got, exp);
    end
    tick();
    bus.cdbGrant = 1'b0;
    setIssue(1'b1, OP_ADD, 32'd40, 32'd4, 4'd4, 5'd4, 32'd0);
    #1;
    got = snap();
    exp = mk(1, 0, 1, 0, 4'd2, 5'd2, 32'd22);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("[TB] FAIL full_count_kept got %h exp %h", got, exp);
    end
    tick();
    idle();
    #1;
    got = snap();
    exp = mk(1, 0, 1, 1, 4'd2, 5'd2, 32'd22);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("[TB] FAIL full_overflow_set got %h exp %h", got, exp);
    end
    bus.cdbGrant = 1'b1;
    tick();
    got = snap();
    exp = mk(1, 1, 1, 1, 4'd3, 5'd3, 32'd33);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("[TB] FAIL full_accepted_entry got %h exp %h", got, exp);
    end
    tick();
    got = snap();
    exp = mk(0, 0, 0, 1, 4'hF, 5'd0, 32'd0);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("[TB] FAIL full_dropped_absent got %h exp %h", got, exp);
    end
  endtask

  task automatic test_flush();
    logic [44:0] got;
    logic [44:0] exp;
    bus.cdbGrant = 1'b0;
    setIssue(1'b1, OP_XOR, 32'hF0, 32'h0F, 4'd5, 5'd5, 32'd0);
    tick();
    setIssue(1'b1, OP_OR, 32'hF0, 32'h0F, 4'd6, 5'd6, 32'd0);
    tick();
    setIssue(1'b1, OP_AND, 32'hFF, 32'h0F, 4'd7, 5'd7, 32'd0);
    bus.flush = 1'b1;
    tick();
    idle();
    #1;
    got = snap();
    exp = mk(0, 0, 0, 1, 4'hF, 5'd0, 32'd0);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("[TB] FAIL flush_empty got %h exp %h", got, exp);
    end
  endtask

  task automatic test_async_reset();
    logic [44:0] got;
    logic [44:0] exp;
    bus.cdbGrant = 1'b0;
    setIssue(1'b1, OP_SLL, 32'd1, 32'd8, 4'd8, 5'd8, 32'd0);
    tick();
    setIssue(1'b1, OP_SRL, 32'h100, 32'd4, 4'd9, 5'd9, 32'd0);
    tick();
    idle();
    #2;
    rst = 1'b0;
    q.delete();
    mOvf = 1'b0;
    #1;
    got = snap();
    exp = mk(0, 0, 0, 0, 4'hF, 5'd0, 32'd0);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("[TB] FAIL async_reset_immediate got %h exp %h", got, exp);
    end
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    setIssue(1'b1, OP_NOP, 32'd1, 32'd1, 4'd2, 5'd2, 32'd0);
    tick();
    setIssue(1'b1, OP_ADD, 32'd1, 32'd1, 4'hF, 5'd3, 32'd0);
    tick();
    idle();
    #1;
    got = snap();
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("[TB] FAIL nop_tagfree_not_pushed got %h exp %h", got, exp);
    end
  endtask

  task automatic test_random();
    logic [44:0] got;
    logic [44:0] exp;
    for (int i = 0; i < 400; i++) begin
      setIssue($urandom_range(0, 3) != 0, 5'($urandom_range(0, 17)), $urandom(),
               ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom(),
               4'($urandom_range(0, 15)), 5'($urandom()), $urandom());
      bus.cdbGrant = ($urandom_range(0, 2) != 0);
      bus.flush    = ($urandom_range(0, 19) == 0);
      #1;
      got = snap();
      exp = modelOut();
      nVec++;
      if (got !== exp) begin
        nErr++;
        $display("[TB] FAIL random[%0d] got %h exp %h", i, got, exp);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    nVec = 0;
    nErr = 0;
    mOvf = 1'b0;
    test_reset();
    test_add();
    test_ops();
    test_back_to_back();
    test_full();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
